// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
// Bundles the fetch (IF) and load/store (D) request handshakes together with
// the single shared memory port. The arbiter binds to the slave modport; the
// requesters and the memory model bind to the master modport.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);
  // Instruction fetch requester
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;

  // Load/store requester
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;

  // Shared memory port
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_wr;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
           mem_addr, mem_wdata, mem_wr
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
           mem_addr, mem_wdata, mem_wr
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one synchronous-read memory port between instruction fetch (IF) and
// the load/store unit (D). One transaction is outstanding at a time; on a
// conflict the requester that was not granted last wins (round robin).
// Every handshake output is a register: gnt is high during ISSUE, rvalid is
// high during the IDLE cycle that follows RESP.
// Optional statistics outputs (conflict_cnt, d_wait_max) are built only when
// the macro ARB_STATS_EN is defined.
module mem_port_arbiter #(
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 64,
  parameter int MEM_LAT = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  mem_port_arbiter_if.slave        bus
`ifdef ARB_STATS_EN
  ,
  output logic [15:0]              conflict_cnt,
  output logic [7:0]               d_wait_max
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  // Number of WAIT cycles a read spends before RESP is MEM_LAT-1.
  localparam logic [2:0] LAT_M1 = 3'(MEM_LAT - 1);

  state_t            stateR, nextStateS;
  logic              pickDS;        // requester chosen in IDLE: 1 = D, 0 = IF
  logic              selDR;         // requester owning the current transaction
  logic              rrLastR;       // last granted requester: 1 = D, 0 = IF
  logic [2:0]        cntR;
  logic [ADDR_W-1:0] latAddrR;
  logic [DATA_W-1:0] latWdataR;
  logic              latWeR;
  logic              ifGntR, dGntR, ifRvalidR, dRvalidR, memWrR;
  logic [DATA_W-1:0] ifRdataR, dRdataR;

  // Next-state selection and round-robin choice of requester
  always_comb begin
    nextStateS = stateR;
    pickDS     = 1'b0;
    case (stateR)
      IDLE: begin
        if (bus.if_req && bus.d_req) begin
          pickDS     = ~rrLastR;
          nextStateS = ISSUE;
        end else if (bus.d_req) begin
          pickDS     = 1'b1;
          nextStateS = ISSUE;
        end else if (bus.if_req) begin
          pickDS     = 1'b0;
          nextStateS = ISSUE;
        end else begin
          nextStateS = IDLE;
        end
      end
      ISSUE: begin
        if (latWeR) begin
          nextStateS = IDLE;
        end else if (MEM_LAT == 1) begin
          nextStateS = RESP;
        end else begin
          nextStateS = WAIT;
        end
      end
      WAIT: begin
        if (cntR == 3'd1) begin
          nextStateS = RESP;
        end else begin
          nextStateS = WAIT;
        end
      end
      RESP:    nextStateS = IDLE;
      default: nextStateS = IDLE;
    endcase
  end

  // State register, request latch, handshake pulses and read-data capture
  always_ff @(posedge clk) begin
    if (reset) begin
      stateR    <= IDLE;
      selDR     <= 1'b0;
      rrLastR   <= 1'b0;
      cntR      <= 3'd0;
      latAddrR  <= '0;
      latWdataR <= '0;
      latWeR    <= 1'b0;
      ifGntR    <= 1'b0;
      dGntR     <= 1'b0;
      ifRvalidR <= 1'b0;
      dRvalidR  <= 1'b0;
      memWrR    <= 1'b0;
      ifRdataR  <= '0;
      dRdataR   <= '0;
    end else begin
      stateR    <= nextStateS;
      ifGntR    <= 1'b0;
      dGntR     <= 1'b0;
      ifRvalidR <= 1'b0;
      dRvalidR  <= 1'b0;
      memWrR    <= 1'b0;
      case (stateR)
        IDLE: begin
          if (nextStateS == ISSUE) begin
            selDR     <= pickDS;
            latAddrR  <= pickDS ? bus.d_addr : bus.if_addr;
            latWdataR <= pickDS ? bus.d_wdata : '0;
            latWeR    <= pickDS & bus.d_we;   // fetch is never a write
            ifGntR    <= ~pickDS;
            dGntR     <= pickDS;
            memWrR    <= pickDS & bus.d_we;
          end
        end
        ISSUE: begin
          rrLastR <= selDR;
          cntR    <= LAT_M1;
        end
        WAIT: cntR <= cntR - 3'd1;
        RESP: begin
          if (selDR) begin
            dRdataR  <= bus.mem_rdata;
            dRvalidR <= 1'b1;
          end else begin
            ifRdataR  <= bus.mem_rdata;
            ifRvalidR <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.if_gnt    = ifGntR;
  assign bus.if_rvalid = ifRvalidR;
  assign bus.if_rdata  = ifRdataR;
  assign bus.d_gnt     = dGntR;
  assign bus.d_rvalid  = dRvalidR;
  assign bus.d_rdata   = dRdataR;
  assign bus.mem_addr  = latAddrR;
  assign bus.mem_wdata = latWdataR;
  assign bus.mem_wr    = memWrR;

`ifdef ARB_STATS_EN
  logic [15:0] conflictCntR;
  logic [7:0]  dWaitCntR;
  logic [7:0]  dWaitMaxR;

  // Saturating conflict count and longest D wait before its grant
  always_ff @(posedge clk) begin
    if (reset) begin
      conflictCntR <= 16'd0;
      dWaitCntR    <= 8'd0;
      dWaitMaxR    <= 8'd0;
    end else begin
      if ((stateR == IDLE) && bus.if_req && bus.d_req && (conflictCntR != 16'hFFFF)) begin
        conflictCntR <= conflictCntR + 16'd1;
      end
      if (dGntR) begin
        dWaitCntR <= 8'd0;
        if (dWaitCntR > dWaitMaxR) begin
          dWaitMaxR <= dWaitCntR;
        end
      end else if (bus.d_req && (dWaitCntR != 8'hFF)) begin
        dWaitCntR <= dWaitCntR + 8'd1;
      end
    end
  end

  assign conflict_cnt = conflictCntR;
  assign d_wait_max   = dWaitMaxR;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
// Three arbiter instances with MEM_LAT = 1, 2, 3, each with its own memory
// model. Read responses are checked against a scoreboard of expected data
// pushed when the request is driven; handshake timing is checked in line.
module tb_mem_port_arbiter;
  localparam int AW = 64;
  localparam int DW = 64;
  localparam int NI = 3;

  typedef struct {
    int          inst;
    bit          isD;
    logic [63:0] data;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int   nTests = 0;
  int   nFail  = 0;
  exp_t sbQ[$];

  logic          ifReq  [NI];
  logic [AW-1:0] ifAddr [NI];
  logic          dReq   [NI];
  logic          dWe    [NI];
  logic [AW-1:0] dAddr  [NI];
  logic [DW-1:0] dWdata [NI];

  logic          ifGnt    [NI];
  logic          ifRvalid [NI];
  logic [DW-1:0] ifRdata  [NI];
  logic          dGnt     [NI];
  logic          dRvalid  [NI];
  logic [DW-1:0] dRdata   [NI];
  logic [AW-1:0] memAddr  [NI];
  logic [DW-1:0] memWdata [NI];
  logic          memWr    [NI];
`ifdef ARB_STATS_EN
  logic [15:0]   confCnt  [NI];
  logic [7:0]    dWaitMax [NI];
`endif

  // Memory contents before any write
  function automatic logic [63:0] memInit(input logic [63:0] a);
    if (a == 64'h40) return 64'h0000_0000_00A0_0093;
    else             return {16'hC0DE, a[47:0]};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nTests++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chkBit(input string tag, input logic obs, input logic exp);
    nTests++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic pushExp(input int inst, input bit isD, input logic [63:0] data);
    sbQ.push_back('{inst: inst, isD: isD, data: data});
  endtask

  task automatic scoreCheck(input int inst, input bit isD, input logic [63:0] data);
    exp_t e;
    chkBit("rvalid expected", 1'(sbQ.size() != 0), 1'b1);
    if (sbQ.size() != 0) begin
      e = sbQ.pop_front();
      chk("rvalid instance", 64'(inst), 64'(e.inst));
      chkBit("rvalid requester", isD, e.isD);
      chk("rdata", data, e.data);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chkAllZero(input int k);
    chkBit("zero if_gnt", ifGnt[k], 1'b0);
    chkBit("zero if_rvalid", ifRvalid[k], 1'b0);
    chk("zero if_rdata", ifRdata[k], 64'd0);
    chkBit("zero d_gnt", dGnt[k], 1'b0);
    chkBit("zero d_rvalid", dRvalid[k], 1'b0);
    chk("zero d_rdata", dRdata[k], 64'd0);
    chk("zero mem_addr", memAddr[k], 64'd0);
    chk("zero mem_wdata", memWdata[k], 64'd0);
    chkBit("zero mem_wr", memWr[k], 1'b0);
  endtask

  for (genvar k = 0; k < NI; k++) begin : g
    mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    assign bus.if_req  = ifReq[k];
    assign bus.if_addr = ifAddr[k];
    assign bus.d_req   = dReq[k];
    assign bus.d_we    = dWe[k];
    assign bus.d_addr  = dAddr[k];
    assign bus.d_wdata = dWdata[k];
    assign ifGnt[k]    = bus.if_gnt;
    assign ifRvalid[k] = bus.if_rvalid;
    assign ifRdata[k]  = bus.if_rdata;
    assign dGnt[k]     = bus.d_gnt;
    assign dRvalid[k]  = bus.d_rvalid;
    assign dRdata[k]   = bus.d_rdata;
    assign memAddr[k]  = bus.mem_addr;
    assign memWdata[k] = bus.mem_wdata;
    assign memWr[k]    = bus.mem_wr;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(k + 1)) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
`ifdef ARB_STATS_EN
      ,
      .conflict_cnt(confCnt[k]),
      .d_wait_max(dWaitMax[k])
`endif
    );

    logic [63:0] memArr  [0:1023];
    bit          written [0:1023];
    logic [63:0] pipe    [0:k];

    // Memory model: synchronous read with k+1 cycles of latency, write at the edge
    always @(posedge clk) begin
      pipe[0] <= written[bus.mem_addr[9:0]] ? memArr[bus.mem_addr[9:0]] : memInit(bus.mem_addr);
      for (int i = 1; i <= k; i++) pipe[i] <= pipe[i-1];
      if (bus.mem_wr) begin
        memArr[bus.mem_addr[9:0]]  <= bus.mem_wdata;
        written[bus.mem_addr[9:0]] <= 1'b1;
      end
    end
    assign bus.mem_rdata = pipe[k];

    // Scoreboard monitor: every rvalid pulse must match the next expected response
    always @(negedge clk) begin
      if (ifRvalid[k] === 1'b1) scoreCheck(k, 1'b0, ifRdata[k]);
      if (dRvalid[k] === 1'b1) scoreCheck(k, 1'b1, dRdata[k]);
    end
  end

  initial begin
    int waited;
    int ifPulses;
    bit got;
    for (int k = 0; k < NI; k++) begin
      ifReq[k] = 1'b0; ifAddr[k] = 64'd0;
      dReq[k] = 1'b0; dWe[k] = 1'b0; dAddr[k] = 64'd0; dWdata[k] = 64'd0;
    end

    // Reset held 3 cycles with a fetch request pending on instance 0
    reset = 1'b1;
    ifReq[0] = 1'b1; ifAddr[0] = 64'h40;
    pushExp(0, 1'b0, 64'h0000_0000_00A0_0093);
    repeat (3) begin
      tick();
      chkBit("gnt during reset", ifGnt[0], 1'b0);
    end
    chkAllZero(0);
    reset = 1'b0;
    tick();
    chkBit("fetch if_gnt", ifGnt[0], 1'b1);
    chkBit("fetch no mem_wr", memWr[0], 1'b0);
    chk("fetch mem_addr", memAddr[0], 64'h40);
    ifReq[0] = 1'b0;
    tick();
    chkBit("fetch gnt one cycle", ifGnt[0], 1'b0);
    chkBit("fetch rvalid early", ifRvalid[0], 1'b0);
    tick();
    chkBit("fetch if_rvalid", ifRvalid[0], 1'b1);
    chk("fetch if_rdata", ifRdata[0], 64'h0000_0000_00A0_0093);
    chkBit("fetch d_gnt quiet", dGnt[0], 1'b0);
    chkBit("fetch d_rvalid quiet", dRvalid[0], 1'b0);
    chk("fetch d_rdata quiet", dRdata[0], 64'd0);
    tick();
    chkBit("fetch rvalid one cycle", ifRvalid[0], 1'b0);

    // Conflict on instance 0: both held for 6 grants, D wins first
    for (int n = 0; n < 6; n++) begin
      if ((n % 2) == 0) pushExp(0, 1'b1, memInit(64'h200));
      else              pushExp(0, 1'b0, 64'h0000_0000_00A0_0093);
    end
    ifReq[0] = 1'b1; ifAddr[0] = 64'h40;
    dReq[0] = 1'b1; dWe[0] = 1'b0; dAddr[0] = 64'h200;
    for (int n = 0; n < 6; n++) begin
      got = 1'b0; waited = 0;
      while (!got && waited < 20) begin
        tick();
        waited++;
        if (ifGnt[0] || dGnt[0]) got = 1'b1;
      end
      chkBit("conflict grant seen", got, 1'b1);
      chkBit("conflict order", dGnt[0], 1'((n % 2) == 0));
      chkBit("conflict single grant", ifGnt[0] & dGnt[0], 1'b0);
      if (n > 0) chk("conflict spacing", 64'(waited), 64'd3);
      if (n == 5) begin
        ifReq[0] = 1'b0;
        dReq[0] = 1'b0;
      end
    end
    repeat (3) tick();
`ifdef ARB_STATS_EN
    chk("conflict_cnt", 64'(confCnt[0]), 64'd6);
`endif

    // Back-to-back D reads on instance 0, address changing after each grant
    ifPulses = 0;
    dReq[0] = 1'b1; dWe[0] = 1'b0; dAddr[0] = 64'h300;
    pushExp(0, 1'b1, memInit(64'h300));
    for (int n = 0; n < 4; n++) begin
      got = 1'b0; waited = 0;
      while (!got && waited < 20) begin
        tick();
        waited++;
        if (ifGnt[0] || ifRvalid[0]) ifPulses++;
        if (dGnt[0]) got = 1'b1;
      end
      chkBit("b2b grant seen", got, 1'b1);
      if (n > 0) chk("b2b spacing", 64'(waited), 64'd3);
      if (n < 3) begin
        dAddr[0] = 64'h300 + 64'(8 * (n + 1));
        pushExp(0, 1'b1, memInit(dAddr[0]));
      end else begin
        dReq[0] = 1'b0;
      end
    end
    repeat (3) begin
      tick();
      if (ifGnt[0] || ifRvalid[0]) ifPulses++;
    end
    chk("b2b no IF pulses", 64'(ifPulses), 64'd0);

    // Write then read on instance 1 (MEM_LAT = 2)
    dReq[1] = 1'b1; dWe[1] = 1'b1; dAddr[1] = 64'h100; dWdata[1] = 64'hDEAD_BEEF_0000_0001;
    tick();
    chkBit("write d_gnt", dGnt[1], 1'b1);
    chkBit("write mem_wr", memWr[1], 1'b1);
    chk("write mem_addr", memAddr[1], 64'h100);
    chk("write mem_wdata", memWdata[1], 64'hDEAD_BEEF_0000_0001);
    dReq[1] = 1'b0; dWe[1] = 1'b0;
    tick();
    chkBit("write mem_wr drops", memWr[1], 1'b0);
    chkBit("write gnt one cycle", dGnt[1], 1'b0);
    dReq[1] = 1'b1; dAddr[1] = 64'h100;
    pushExp(1, 1'b1, 64'hDEAD_BEEF_0000_0001);
    tick();
    chkBit("read d_gnt", dGnt[1], 1'b1);
    chkBit("read no mem_wr", memWr[1], 1'b0);
    dReq[1] = 1'b0;
    tick();
    chkBit("read wait no rvalid", dRvalid[1], 1'b0);
    chkBit("read wait no mem_wr", memWr[1], 1'b0);
    tick();
    chkBit("read resp no rvalid", dRvalid[1], 1'b0);
    tick();
    chkBit("read d_rvalid", dRvalid[1], 1'b1);
    chk("read d_rdata", dRdata[1], 64'hDEAD_BEEF_0000_0001);
    tick();
    chkBit("read rvalid one cycle", dRvalid[1], 1'b0);

    // Reset during WAIT of a read on instance 2 (MEM_LAT = 3)
    dReq[2] = 1'b1; dWe[2] = 1'b0; dAddr[2] = 64'h180;
    tick();
    chkBit("abort d_gnt", dGnt[2], 1'b1);
    dReq[2] = 1'b0;
    tick();
    chkBit("abort wait no rvalid", dRvalid[2], 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chkAllZero(0);
    chkAllZero(2);
`ifdef ARB_STATS_EN
    chk("conflict_cnt cleared", 64'(confCnt[0]), 64'd0);
    chk("d_wait_max cleared", 64'(dWaitMax[0]), 64'd0);
`endif
    repeat (8) begin
      tick();
      chkBit("abort no rvalid", dRvalid[2], 1'b0);
      chkBit("abort no gnt", dGnt[2], 1'b0);
      chkBit("abort no mem_wr", memWr[2], 1'b0);
    end

    // Instance 2 accepts a fresh fetch after the abort
    ifReq[2] = 1'b1; ifAddr[2] = 64'h40;
    pushExp(2, 1'b0, 64'h0000_0000_00A0_0093);
    tick();
    chkBit("post-abort if_gnt", ifGnt[2], 1'b1);
    ifReq[2] = 1'b0;
    repeat (3) begin
      tick();
      chkBit("lat3 rvalid early", ifRvalid[2], 1'b0);
    end
    tick();
    chkBit("lat3 if_rvalid", ifRvalid[2], 1'b1);
    chk("lat3 if_rdata", ifRdata[2], 64'h0000_0000_00A0_0093);
    repeat (2) tick();

    chk("scoreboard drained", 64'(sbQ.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one 64-bit data memory port between two requesters: instruction fetch (IF) and the load/store unit (D).
- Sits between the multicycle control/datapath and the single memory instance. The memory has a synchronous read with MEM_LAT-cycle latency.
- Serialises accesses with one outstanding transaction at a time.
- Round-robin arbitration on conflict, req/gnt/rvalid handshake per requester.

Parameters:
- ADDR_W, 64, address width of requesters and memory.
- DATA_W, 64, data width.
- MEM_LAT, 1, cycles from ISSUE to valid mem_rdata; legal 1..4.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high reset
- if_req  in  1  fetch read request; held until if_gnt
- if_addr  in  ADDR_W  fetch address; stable while if_req
- if_gnt  out  1  one-cycle pulse: fetch request accepted and issued
- if_rvalid  out  1  one-cycle pulse: if_rdata valid
- if_rdata  out  DATA_W  fetch read data
- d_req  in  1  data request; held until d_gnt
- d_we  in  1  1 = write, 0 = read; stable while d_req
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  write data
- d_gnt  out  1  one-cycle pulse: data request accepted and issued
- d_rvalid  out  1  one-cycle pulse: d_rdata valid; reads only
- d_rdata  out  DATA_W  data read result
- mem_addr  out  ADDR_W  memory address, driven as both raddress and waddress
- mem_wdata  out  DATA_W  memory write data
- mem_wr  out  1  memory write enable
- mem_rdata  in  DATA_W  memory read data

Behaviour:
- Reset values:
  - all outputs 0
  - state IDLE
  - rr_last = IF, so D wins the first conflict
  - latency counter 0
- Reset asserted mid-transaction aborts it immediately: no gnt or rvalid afterwards, and mem_wr is 0 in the following cycle.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Sample if_req and d_req.
  - Neither asserted: stay in IDLE.
  - Only one asserted: select it.
  - Both asserted: select the requester not equal to rr_last.
  - Latch the selected addr, we and wdata into internal registers; go to ISSUE.
- ISSUE (exactly 1 cycle):
  - mem_addr and mem_wdata come from the latched registers.
  - mem_wr = latched we (D only; IF is never a write).
  - Pulse the selected gnt; update rr_last to the selected requester.
  - Write: return to IDLE.
  - Read with MEM_LAT = 1: go to RESP.
  - Read with MEM_LAT > 1: load counter = MEM_LAT-1 and go to WAIT.
- WAIT:
  - mem_addr is held at the latched address; mem_wr = 0.
  - Decrement the counter; go to RESP when it reaches 1.
- RESP:
  - Capture mem_rdata into the selected requester's rdata register.
  - Pulse its rvalid in the next cycle, which is IDLE.
  - The other requester's rdata is unchanged.
- Latency:
  - Read: gnt at cycle T+1 after req is sampled at T; rvalid at T+2+MEM_LAT.
  - Write: gnt at T+1, memory is written at the end of T+1.
  - Minimum gap between issues: 2 cycles for writes, MEM_LAT+2 for reads.
- A request dropped before gnt is ignored if it is not yet sampled. Once latched, it completes.
- rdata registers hold their value until the next read for the same requester.
- mem_wr is never asserted outside ISSUE.
- Starvation-free: with both requesters continuously asserting, grants strictly alternate.

Optional Feature:
- Macro ARB_STATS_EN.
- When defined, add two outputs:
  - conflict_cnt, out, 16: increments in IDLE when both reqs are sampled.
  - d_wait_max, out, 8: maximum cycles d_req was held before d_gnt.
  - Both saturate at all-ones and clear on reset.
- When undefined, the ports and logic are absent and the behaviour is otherwise identical.

Test Plan:
- Reset: hold reset 3 cycles with if_req=1 -> no gnt during reset; all outputs 0; if_gnt first appears 2 cycles after reset deasserts (IDLE sample, then ISSUE).
- Single fetch, MEM_LAT=1: if_addr=0x40, memory[0x40]=0x00A00093 -> if_gnt at T+1, if_rvalid at T+3 with if_rdata=0x00A00093; d_* outputs stay 0.
- Data write then read, MEM_LAT=2:
  - Write 0xDEADBEEF00000001 to 0x100 -> mem_wr=1 only in the d_gnt cycle.
  - Subsequent read of 0x100 -> d_rvalid 4 cycles after its d_gnt-1 sample, d_rdata=0xDEADBEEF00000001.
- Conflict: both req held continuously for 6 grants -> order D, IF, D, IF, D, IF; with ARB_STATS_EN, conflict_cnt=6 (or 5 if the last sample is single-requester).
- Reset mid-read: assert reset in the WAIT cycle (MEM_LAT=3) -> no rvalid ever appears for that read; FSM is in IDLE next cycle.
- Back-to-back reads from one requester, MEM_LAT=1: d_req held with address changing after each d_gnt -> d_gnt spacing 3 cycles; each d_rdata matches its address; no IF pulses.
